// File: rtl/player_pkg.sv
// Shared constants for the player controller: game state codes, sprite frame codes,
// facing directions and playfield geometry.
package player_pkg;

  localparam int unsigned FIELD_W = 320;
  localparam int unsigned FIELD_H = 240;
  localparam int unsigned SPR     = 20;
  localparam int unsigned MAX_X   = FIELD_W - SPR;
  localparam int unsigned MAX_Y   = FIELD_H - SPR;
  localparam int unsigned COORD_W = 9;
  localparam int unsigned GS_W    = 4;
  localparam int unsigned FRAME_W = 4;

  typedef enum logic [GS_W-1:0] {
    TITLE    = 4'd0,
    STAGE1   = 4'd1,
    STAGE2   = 4'd2,
    STAGE3   = 4'd3,
    SUCCESS1 = 4'd4,
    SUCCESS2 = 4'd5,
    SUCCESS3 = 4'd6,
    WIN      = 4'd7,
    FAIL     = 4'd8
  } game_state_e;

  typedef enum logic [FRAME_W-1:0] {
    UP1, UP2, UP3, RIGHT1, RIGHT2, RIGHT3,
    LEFT1, LEFT2, LEFT3, DOWN1, DOWN2, DOWN3
  } frame_e;

  typedef enum logic [1:0] {FACE_UP, FACE_RIGHT, FACE_LEFT, FACE_DOWN} facing_e;

  function automatic logic is_stage(logic [GS_W-1:0] s);
    return (s == STAGE1) || (s == STAGE2) || (s == STAGE3);
  endfunction

  // Walk cycle: phase 0,1,2,3 shows frame offsets 1,0,2,0
  function automatic logic [1:0] phase_offset(logic [1:0] ph);
    case (ph)
      2'd0:    return 2'd1;
      2'd2:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [FRAME_W-1:0] frame_of(facing_e f, logic [1:0] off);
    return FRAME_W'({2'b00, f} * 4'd3 + {2'b00, off});
  endfunction

endpackage

// File: rtl/player_ctrl_tick_gen.sv
// Free-running divider producing a registered one-cycle pulse each DIV clocks.
module tick_gen #(
  parameter int unsigned DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/player_ctrl.sv
// Player position, clamping and walk animation, stepped on an internal move tick.
// Optional PLAYER_SPRINT_EN: key_sprint doubles the step and the animation rate.
module player_ctrl
  import player_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1_000_000,
  parameter int unsigned STEP     = 2,
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned START_X  = 150,
  parameter int unsigned START_Y  = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [GS_W-1:0]     state,
  input  logic                key_up,
  input  logic                key_down,
  input  logic                key_left,
  input  logic                key_right,
  input  logic                key_sprint,
  output logic [COORD_W-1:0]  player_x,
  output logic [COORD_W-1:0]  player_y,
  output logic [FRAME_W-1:0]  player_state,
  output logic                moving
);

  localparam int unsigned ACW = $clog2(ANIM_DIV + 2);
  localparam logic [COORD_W:0]   STEP1  = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0]   MAXX10 = (COORD_W+1)'(MAX_X);
  localparam logic [COORD_W:0]   MAXY10 = (COORD_W+1)'(MAX_Y);
  localparam logic [COORD_W-1:0] X0     = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y0     = COORD_W'(START_Y);
  localparam logic [ACW-1:0]     ADIV   = ACW'(ANIM_DIV);

  logic                tick_p;
  logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  logic                moving_q, moving_d;
  facing_e             face_q, face_d;
  logic [1:0]          phase_q, phase_d;
  logic [ACW-1:0]      anim_q, anim_d, anim_sum;
  logic [GS_W-1:0]     prev_state_q, prev_state_d;
  logic [COORD_W:0]    step_c;
  logic [ACW-1:0]      anim_inc_c;
  logic                entry_c, dir_vld;
  facing_e             dir;

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick_p)
  );

`ifdef PLAYER_SPRINT_EN
  localparam logic [COORD_W:0] STEP2 = (COORD_W+1)'(2 * STEP);
  assign step_c     = key_sprint ? STEP2 : STEP1;
  assign anim_inc_c = key_sprint ? ACW'(2) : ACW'(1);
`else
  logic unused_sprint;
  assign unused_sprint = key_sprint;
  assign step_c        = STEP1;
  assign anim_inc_c    = ACW'(1);
`endif

  // Saturating coordinate move: clamp to max going up, to zero going down
  function automatic logic [COORD_W-1:0] bump(logic [COORD_W-1:0] c, logic inc,
                                               logic [COORD_W:0] st, logic [COORD_W:0] mx);
    logic [COORD_W:0] c10;
    logic [COORD_W:0] s;
    c10 = {1'b0, c};
    s   = c10 + st;
    if (inc) return (s > mx) ? mx[COORD_W-1:0] : s[COORD_W-1:0];
    return (c10 < st) ? '0 : COORD_W'(c10 - st);
  endfunction

  assign entry_c = is_stage(state) && (state != prev_state_q);

  // Opposing keys cancel per axis, then up > down > left > right
  always_comb begin
    dir_vld = 1'b1;
    dir     = FACE_UP;
    if (key_up && !key_down)          dir = FACE_UP;
    else if (key_down && !key_up)     dir = FACE_DOWN;
    else if (key_left && !key_right)  dir = FACE_LEFT;
    else if (key_right && !key_left)  dir = FACE_RIGHT;
    else                              dir_vld = 1'b0;
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    frame_d      = frame_q;
    moving_d     = moving_q;
    face_d       = face_q;
    phase_d      = phase_q;
    anim_d       = anim_q;
    prev_state_d = state;
    anim_sum     = anim_q + anim_inc_c;
    if (entry_c) begin
      x_d      = X0;
      y_d      = Y0;
      frame_d  = UP1;
      moving_d = 1'b0;
      face_d   = FACE_UP;
      phase_d  = 2'd0;
      anim_d   = '0;
    end else if (!is_stage(state)) begin
      moving_d = 1'b0;
    end else if (tick_p) begin
      if (!dir_vld) begin
        moving_d = 1'b0;
        phase_d  = 2'd0;
        anim_d   = '0;
        frame_d  = frame_of(face_q, 2'd0);
      end else begin
        moving_d = 1'b1;
        face_d   = dir;
        case (dir)
          FACE_UP:    y_d = bump(y_q, 1'b0, step_c, MAXY10);
          FACE_DOWN:  y_d = bump(y_q, 1'b1, step_c, MAXY10);
          FACE_LEFT:  x_d = bump(x_q, 1'b0, step_c, MAXX10);
          default:    x_d = bump(x_q, 1'b1, step_c, MAXX10);
        endcase
        if (anim_sum >= ADIV) begin
          anim_d  = '0;
          phase_d = phase_q + 2'd1;
        end else begin
          anim_d  = anim_sum;
        end
        frame_d = frame_of(dir, phase_offset(phase_d));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= X0;
      y_q          <= Y0;
      frame_q      <= UP1;
      moving_q     <= 1'b0;
      face_q       <= FACE_UP;
      phase_q      <= 2'd0;
      anim_q       <= '0;
      prev_state_q <= TITLE;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      frame_q      <= frame_d;
      moving_q     <= moving_d;
      face_q       <= face_d;
      phase_q      <= phase_d;
      anim_q       <= anim_d;
      prev_state_q <= prev_state_d;
    end
  end

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = frame_q;
  assign moving       = moving_q;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl with a short move tick (TICK_DIV=4, STEP=2, ANIM_DIV=1).
module tb_player_ctrl;
  import player_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] state = TITLE;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       key_sprint = 1'b0;
  logic [8:0] player_x, player_y;
  logic [3:0] player_state;
  logic       moving;

  int unsigned npass = 0, nfail = 0, ntot = 0, cyc = 0;

  always #5 clk = ~clk;

  player_ctrl #(
    .TICK_DIV(4), .STEP(2), .ANIM_DIV(1), .START_X(150), .START_Y(200)
  ) dut (
    .clk(clk), .rst_n(rst_n), .state(state),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .key_sprint(key_sprint),
    .player_x(player_x), .player_y(player_y), .player_state(player_state), .moving(moving)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    cyc++;
  endtask

  // Edges counted from reset release; the tick pulse is sampled on edges 5, 9, 13, ...
  task automatic to_upd();
    do step_clk(); while (!((cyc % 4 == 1) && (cyc >= 5)));
    #1;
  endtask

  task automatic to_pre();
    do step_clk(); while (cyc % 4 != 0);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk("rst_x", 16'(player_x), 16'd150);
    chk("rst_y", 16'(player_y), 16'd200);
    chk("rst_frame", 16'(player_state), 16'd0);
    chk("rst_moving", 16'(moving), 16'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    cyc = 0;

    key_right = 1'b1;
    repeat (20) step_clk();
    #1;
    chk("title_x", 16'(player_x), 16'd150);
    chk("title_moving", 16'(moving), 16'd0);

    state = STAGE1;
    to_upd();
    chk("entry_tick_x", 16'(player_x), 16'd150);
    chk("entry_tick_frame", 16'(player_state), 16'd0);
    chk("entry_tick_moving", 16'(moving), 16'd0);
    to_upd();
    chk("walk1_x", 16'(player_x), 16'd152);
    chk("walk1_frame", 16'(player_state), 16'd3);
    chk("walk1_moving", 16'(moving), 16'd1);
    to_upd();
    chk("walk2_x", 16'(player_x), 16'd154);
    chk("walk2_frame", 16'(player_state), 16'd5);
    to_upd();
    chk("walk3_x", 16'(player_x), 16'd156);
    chk("walk3_frame", 16'(player_state), 16'd3);
    key_right = 1'b0;
    to_upd();
    chk("idle_frame", 16'(player_state), 16'd3);
    chk("idle_moving", 16'(moving), 16'd0);
    chk("idle_x", 16'(player_x), 16'd156);

    key_right = 1'b1;
    repeat (71) to_upd();
    chk("near_right_x", 16'(player_x), 16'd298);
    to_upd();
    chk("right_wall_x", 16'(player_x), 16'd300);
    chk("right_wall_frame", 16'(player_state), 16'd4);
    to_upd();
    chk("right_push_x", 16'(player_x), 16'd300);
    chk("right_push_moving", 16'(moving), 16'd1);
    chk("right_push_frame", 16'(player_state), 16'd3);

    key_right = 1'b0;
    key_left  = 1'b1;
    repeat (149) to_upd();
    chk("near_left_x", 16'(player_x), 16'd2);
    to_upd();
    chk("left_wall_x", 16'(player_x), 16'd0);
    to_upd();
    chk("left_push_x", 16'(player_x), 16'd0);
    chk("left_push_frame", 16'(player_state), 16'd7);

    key_left = 1'b0;
    key_down = 1'b1;
    repeat (9) to_upd();
    chk("near_bottom_y", 16'(player_y), 16'd218);
    to_upd();
    chk("bottom_y", 16'(player_y), 16'd220);
    to_upd();
    chk("bottom_push_y", 16'(player_y), 16'd220);
    chk("bottom_push_frame", 16'(player_state), 16'd9);

    key_up = 1'b1;
    to_upd();
    chk("updown_y", 16'(player_y), 16'd220);
    chk("updown_moving", 16'(moving), 16'd0);
    chk("updown_frame", 16'(player_state), 16'd9);
    key_down = 1'b0;
    key_left = 1'b1;
    to_upd();
    chk("upleft_y", 16'(player_y), 16'd218);
    chk("upleft_x", 16'(player_x), 16'd0);
    chk("upleft_frame", 16'(player_state), 16'd0);
    chk("upleft_moving", 16'(moving), 16'd1);
    to_upd();
    chk("up2_y", 16'(player_y), 16'd216);
    chk("up2_frame", 16'(player_state), 16'd2);

    state = SUCCESS1;
    to_upd();
    to_upd();
    chk("frozen_y", 16'(player_y), 16'd216);
    chk("frozen_x", 16'(player_x), 16'd0);
    chk("frozen_frame", 16'(player_state), 16'd2);
    chk("frozen_moving", 16'(moving), 16'd0);

    key_up   = 1'b0;
    key_left = 1'b0;
    state    = STAGE2;
    step_clk();
    #1;
    chk("stage2_x", 16'(player_x), 16'd150);
    chk("stage2_y", 16'(player_y), 16'd200);
    chk("stage2_frame", 16'(player_state), 16'd0);

    key_right = 1'b1;
    to_upd();
    chk("stage2_walk_x", 16'(player_x), 16'd152);
    to_pre();
    state = STAGE3;
    step_clk();
    #1;
    chk("stage3_entry_x", 16'(player_x), 16'd150);
    chk("stage3_entry_moving", 16'(moving), 16'd0);
    to_upd();
    chk("stage3_walk_x", 16'(player_x), 16'd152);
    chk("stage3_walk_moving", 16'(moving), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_x", 16'(player_x), 16'd150);
    chk("async_rst_y", 16'(player_y), 16'd200);
    chk("async_rst_frame", 16'(player_state), 16'd0);
    chk("async_rst_moving", 16'(moving), 16'd0);

    key_sprint = 1'b1;
    #3 rst_n = 1'b1;
    cyc = 0;
    to_upd();
`ifdef PLAYER_SPRINT_EN
    chk("sprint_x", 16'(player_x), 16'd154);
`else
    chk("sprint_x", 16'(player_x), 16'd152);
`endif
    chk("sprint_frame", 16'(player_state), 16'd3);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
